// File: rtl/led_pattern_pkg.sv
// Shared encodings for the LED pattern engine: mode and direction values,
// PWM counter width and a one-hot helper.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_SHIFT  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_HOLD   = 2'd3
  } led_mode_e;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } led_dir_e;

  localparam int PWM_W = 8;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control/status bundle of the LED pattern engine. No valid/ready handshake:
// every input is a level sampled on each rising clk edge, and every output is
// a registered level (step_pulse is a one-cycle strobe).
interface led_pattern_gen_if #(
  parameter int LED_W      = 4,
  parameter int PRESCALE_W = 24
);
  logic                  en;
  logic [1:0]            mode;
  logic [PRESCALE_W-1:0] div_max;
  logic [7:0]            duty;
  logic [LED_W-1:0]      led_out;
  logic                  step_pulse;
  logic                  dbg_dir;

  modport master (
    output en, mode, div_max, duty,
    input  led_out, step_pulse, dbg_dir
  );

  modport slave (
    input  en, mode, div_max, duty,
    output led_out, step_pulse, dbg_dir
  );
endinterface

// File: rtl/led_prescaler.sv
// Step-rate divider: tick is a combinational strobe, high on enabled cycles
// once the counter has reached div_max.
module led_prescaler #(
  parameter int PRESCALE_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] div_max,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;

  // >= rather than == so lowering div_max below the count fires at once.
  always_comb begin
    tick      = en && (pre_cnt_q >= div_max);
    pre_cnt_d = pre_cnt_q;
    if (tick) begin
      pre_cnt_d = '0;
    end else if (en) begin
      pre_cnt_d = pre_cnt_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: prescaled count/rotate/bounce/hold patterns on LED_W LEDs.
// Optional brightness PWM on the LED drive when LED_PWM_EN is defined.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int LED_W      = 4,
  parameter int PRESCALE_W = 24
) (
  input logic               clk,
  input logic               rst,
  led_pattern_gen_if.slave  bus
);

  logic             tick;
  logic [LED_W-1:0] pat_q, pat_d;
  led_dir_e         dir_q, dir_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             step_q;

  led_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.en),
    .div_max (bus.div_max),
    .tick    (tick)
  );

  always_comb begin
    pat_d = pat_q;
    dir_d = dir_q;
    if (tick) begin
      case (bus.mode)
        MODE_COUNT: pat_d = pat_q + LED_W'(1);
        MODE_SHIFT: pat_d = (pat_q == '0) ? LED_W'(1)
                                          : {pat_q[LED_W-2:0], pat_q[LED_W-1]};
        MODE_BOUNCE: begin
          // Any non-one-hot pattern (including 0) restarts the sweep.
          if (!is_onehot(32'(pat_q))) begin
            pat_d = LED_W'(1);
            dir_d = LEFT;
          end else if (dir_q == LEFT) begin
            if (pat_q[LED_W-1]) begin
              dir_d = RIGHT;
              pat_d = pat_q >> 1;
            end else begin
              pat_d = pat_q << 1;
            end
          end else begin
            if (pat_q[0]) begin
              dir_d = LEFT;
              pat_d = pat_q << 1;
            end else begin
              pat_d = pat_q >> 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic             pwm_on;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    pwm_on    = (pwm_cnt_q < bus.duty);
    led_d     = pat_d & {LED_W{pwm_on}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`else
  logic unused_duty;
  assign unused_duty = ^bus.duty;

  always_comb begin
    led_d = pat_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= '0;
      dir_q  <= LEFT;
      led_q  <= '0;
      step_q <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
      step_q <= tick;
    end
  end

  assign bus.led_out    = led_q;
  assign bus.step_pulse = step_q;
  assign bus.dbg_dir    = dir_q;

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern engine: a programmable prescaler paces a LED_W-bit pattern register through count, rotate, bounce or hold modes. It is the successor to the fixed 4-bit shift/count LED blocks fed by the top-level free-running counter, and it owns its own divider. It sits in the static top, clocked by the PS-sourced PL clock and driving the general-purpose LEDs directly.

Parameters:
LED_W, 4, pattern/LED width; legal range 2..32.
PRESCALE_W, 24, width of the prescaler counter and div_max.

Ports:
clk  in  1  PL clock; single clock domain.
rst  in  1  reset, synchronous, active-high.
en  in  1  advance enable; low freezes the prescaler and the pattern.
mode  in  2  0=COUNT, 1=SHIFT, 2=BOUNCE, 3=HOLD.
div_max  in  PRESCALE_W  step period minus 1, in clk cycles.
duty  in  8  PWM brightness; ignored unless LED_PWM_EN is defined.
led_out  out  LED_W  registered LED drive.
step_pulse  out  1  one-cycle strobe, high in the cycle led_out shows a new step.

Behaviour:
- Reset (rst=1 at a clk edge; overrides en and every other input): pre_cnt=0, pat=0, dir=LEFT, led_out=0, step_pulse=0. Reset mid-operation aborts the current step with no partial update.
- Prescaler: tick = en & (pre_cnt >= div_max).
  - On tick, pre_cnt <= 0.
  - If en=1 and no tick, pre_cnt <= pre_cnt+1.
  - If en=0, pre_cnt holds.
  - div_max=0 gives a tick every enabled cycle.
  - The >= compare means that when div_max is lowered below pre_cnt, tick fires on the next enabled cycle. No wrap-through.
- Pattern update occurs only on a tick. mode is sampled at that tick; a mode change does not clear pat.
  - COUNT: pat <= pat+1, modulo 2^LED_W (all-ones wraps to 0).
  - SHIFT: if pat==0, pat <= 1. Otherwise rotate left: {pat[LED_W-2:0], pat[LED_W-1]}. Non-one-hot patterns rotate unchanged in shape.
  - BOUNCE: if pat is not exactly one-hot, pat <= 1 and dir <= LEFT. Otherwise:
    - dir=LEFT: if pat[LED_W-1], then dir <= RIGHT and pat <= pat>>1; else pat <= pat<<1.
    - dir=RIGHT: if pat[0], then dir <= LEFT and pat <= pat<<1; else pat <= pat>>1.
    - End LEDs therefore light once per sweep, with no double dwell.
  - HOLD: pat and dir hold. step_pulse still fires on each tick (heartbeat).
- Latency: tick evaluated in cycle t; pat, led_out and step_pulse all change at the edge ending cycle t. step_pulse is a register (tick delayed one edge), so it is high exactly in the first cycle of the new led_out value.
- Step period = div_max+1 enabled cycles.
- Without PWM: led_out = pat.

Optional Feature:
Macro LED_PWM_EN.
- Defined: adds an 8-bit free-running pwm_cnt (reset 0, increments every cycle regardless of en, wraps 255->0). pwm_on = (pwm_cnt < duty).
  - led_out registered as pat & {LED_W{pwm_on}}.
  - duty=0 gives always dark; duty=255 gives on 255 of every 256 cycles.
  - step_pulse is unaffected.
- Undefined: no pwm_cnt, duty unconnected internally, led_out = pat.

Decomposition:
- Package led_pattern_pkg: mode encoding constants (MODE_COUNT=0, MODE_SHIFT=1, MODE_BOUNCE=2, MODE_HOLD=3), direction constants (LEFT=0, RIGHT=1), PWM_W=8.
- One sub-module: led_prescaler (clk, rst, en, div_max -> tick), parameterised by PRESCALE_W.
- Pattern next-state logic and the PWM stage stay in led_pattern_gen.

Test Plan:
1. LED_W=4, rst then en=1, div_max=0, mode=0 -> led_out 1,2,...,15,0,1 on consecutive cycles; step_pulse high every cycle.
2. mode=1, div_max=3 from reset -> led_out 0->1->2->4->8->1, each held 4 cycles; step_pulse high once per 4 cycles, aligned with each change.
3. mode=2, div_max=0 from reset -> 1,2,4,8,4,2,1,2. Then force pat=0x5 via mode=0 ticks and switch to mode=2 -> next step yields 1.
4. en=0 for 10 cycles mid-period -> pre_cnt frozen, no step_pulse, led_out stable. en=1 resumes the remaining count. mode=3 -> led_out constant while step_pulse continues each period.
5. div_max=100, wait until pre_cnt=50, set div_max=10 -> step_pulse on the next cycle, then every 11 cycles. Assert rst mid-period -> all outputs 0 at the next edge.
6. LED_PWM_EN defined, mode=3, pat=0xF, duty=64 -> led_out=0xF for exactly 64 of every 256 cycles. duty=0 -> led_out=0 permanently.
